// File: rtl/pipeline_step_controller_pkg.sv
// Shared definitions for the pipeline step controller and the debug unit
// that decodes its o_state readout.
//   STATE_W  : width of the state readout
//   state_e  : controller state encoding (codes 6 and 7 are illegal)
//   mode_e   : session mode latched when a session starts
package pipeline_step_controller_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STEP      = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_DEBUG = 1'b1
    } mode_e;

    // States in which the pipeline advances on the following negedge.
    function automatic logic state_steps(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

    // States that make up an active session.
    function automatic logic state_busy(input state_e s);
        return (s == ST_CLEAR) || (s == ST_RUN) ||
               (s == ST_STEP_WAIT) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/pipeline_step_controller_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to zero (wins over en)
//   en         : count enable; holds at all-ones instead of wrapping
//   count      : current count
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_step_controller.sv
// Pipeline step sequencer: produces the common step enable for all
// inter-stage registers and the PC, in continuous-run or single-step mode,
// clears the pipeline at session start and stops when a halt reaches WB.
//   i_clk          : clock (controller on posedge, pipeline on negedge)
//   i_reset        : asynchronous active-low reset
//   i_start_run    : start continuous session (IDLE only, wins over debug)
//   i_start_debug  : start single-step session (IDLE only)
//   i_step_req     : one-cycle request for one step (STEP_WAIT only)
//   i_abort        : return to IDLE from any state, counter kept
//   i_load_busy    : instruction memory loading, blocks session start
//   i_halt_wb      : halt instruction present at MEM_WB output
//   o_step         : step enable to pipeline registers and PC
//   o_pipe_clear   : one-cycle synchronous clear of pipeline registers
//   o_busy         : session active
//   o_done         : halt reached, session finished
//   o_state        : state encoding for debug readout
//   o_cycle_count  : number of cycles with o_step=1 in this session
module pipeline_step_controller
    import pipeline_step_controller_pkg::*;
#(
    parameter int unsigned NB_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start_run,
    input  logic                 i_start_debug,
    input  logic                 i_step_req,
    input  logic                 i_abort,
    input  logic                 i_load_busy,
    input  logic                 i_halt_wb,
    output logic                 o_step,
    output logic                 o_pipe_clear,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [STATE_W-1:0]   o_state,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    state_e state_q, state_d;
    mode_e  mode_q,  mode_d;
    logic   step_q,  step_d;
    logic   clear_q, clear_d;
    logic   busy_q,  busy_d;
    logic   done_q,  done_d;
    logic   cnt_clr;

    // Next-state logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_load_busy) begin
                        if (i_start_run) begin
                            state_d = ST_CLEAR;
                            mode_d  = MODE_RUN;
                        end else if (i_start_debug) begin
                            state_d = ST_CLEAR;
                            mode_d  = MODE_DEBUG;
                        end
                    end
                end
                ST_CLEAR: begin
                    state_d = (mode_q == MODE_DEBUG) ? ST_STEP_WAIT : ST_RUN;
                end
                ST_RUN: begin
                    if (i_halt_wb) begin
                        state_d = ST_DONE;
                    end
                end
                ST_STEP_WAIT: begin
                    if (i_halt_wb) begin
                        state_d = ST_DONE;
                    end else if (i_step_req) begin
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    // Requests seen here are deliberately not queued.
                    state_d = i_halt_wb ? ST_DONE : ST_STEP_WAIT;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they are registered and
    // change only at posedge, giving the negedge pipeline half a cycle.
    always_comb begin
        step_d  = state_steps(state_d);
        clear_d = (state_d == ST_CLEAR);
        busy_d  = state_busy(state_d);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RUN;
            step_q  <= 1'b0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            clear_q <= clear_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Clearing on entry to CLEAR makes the count read 0 alongside
    // o_pipe_clear; each registered step cycle adds one at its closing edge.
    assign cnt_clr = (state_d == ST_CLEAR);

    sat_counter #(
        .WIDTH (NB_CYCLES)
    ) u_cycle_counter (
        .clk   (i_clk),
        .rst_n (i_reset),
        .clr   (cnt_clr),
        .en    (step_q),
        .count (o_cycle_count)
    );

    assign o_step       = step_q;
    assign o_pipe_clear = clear_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_pipeline_step_controller.sv
module tb_pipeline_step_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_run = 1'b0, start_debug = 1'b0, step_req = 1'b0;
    logic abort = 1'b0, load_busy = 1'b0, halt = 1'b0;

    logic        a_step, a_clear, a_busy, a_done;
    logic [2:0]  a_state;
    logic [31:0] a_cnt;
    logic        b_step, b_clear, b_busy, b_done;
    logic [2:0]  b_state;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_step_controller dut32 (
        .i_clk(clk), .i_reset(rst_n), .i_start_run(start_run),
        .i_start_debug(start_debug), .i_step_req(step_req), .i_abort(abort),
        .i_load_busy(load_busy), .i_halt_wb(halt), .o_step(a_step),
        .o_pipe_clear(a_clear), .o_busy(a_busy), .o_done(a_done),
        .o_state(a_state), .o_cycle_count(a_cnt)
    );

    pipeline_step_controller #(.NB_CYCLES(4)) dut4 (
        .i_clk(clk), .i_reset(rst_n), .i_start_run(start_run),
        .i_start_debug(start_debug), .i_step_req(step_req), .i_abort(abort),
        .i_load_busy(load_busy), .i_halt_wb(halt), .o_step(b_step),
        .o_pipe_clear(b_clear), .o_busy(b_busy), .o_done(b_done),
        .o_state(b_state), .o_cycle_count(b_cnt)
    );

    // Reference model: session phase as a number, executed cycles as an
    // unbounded integer; saturation applied only when forming expectations.
    int      m_state;
    bit      m_debug;
    longint  m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_debug = 0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        int nxt;
        if (m_state == 2 || m_state == 4) m_cnt++;
        nxt = m_state;
        if (abort) nxt = 0;
        else begin
            case (m_state)
                0: if (!load_busy) begin
                       if (start_run) begin nxt = 1; m_debug = 0; end
                       else if (start_debug) begin nxt = 1; m_debug = 1; end
                   end
                1: nxt = m_debug ? 3 : 2;
                2: if (halt) nxt = 5;
                3: if (halt) nxt = 5; else if (step_req) nxt = 4;
                4: nxt = halt ? 5 : 3;
                5: nxt = 5;
                default: nxt = 0;
            endcase
        end
        if (nxt == 1) m_cnt = 0;
        m_state = nxt;
    endtask

    task automatic compare_model();
        logic e_step, e_clear, e_busy, e_done;
        longint e4;
        e_step  = (m_state == 2) || (m_state == 4);
        e_clear = (m_state == 1);
        e_busy  = (m_state >= 1) && (m_state <= 4);
        e_done  = (m_state == 5);
        e4      = (m_cnt > 15) ? 15 : m_cnt;
        check("state32", 64'(a_state), 64'(m_state));
        check("step32",  64'(a_step),  64'(e_step));
        check("clear32", 64'(a_clear), 64'(e_clear));
        check("busy32",  64'(a_busy),  64'(e_busy));
        check("done32",  64'(a_done),  64'(e_done));
        check("count32", 64'(a_cnt),   64'(m_cnt));
        check("state4",  64'(b_state), 64'(m_state));
        check("step4",   64'(b_step),  64'(e_step));
        check("count4",  64'(b_cnt),   64'(e4));
    endtask

    task automatic clear_inputs();
        start_run = 0; start_debug = 0; step_req = 0;
        abort = 0; load_busy = 0; halt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        compare_model();
        @(posedge clk);
        #1;
        compare_model();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic sr, sd, req, ab, ld, hl;
        int   st;
        logic step, clr, busy, done;
        int   cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic sr, sd, req, ab, ld, hl,
                                input int st, input logic step, clr, busy, done,
                                input int cnt);
        vec_t v;
        v.sr = sr; v.sd = sd; v.req = req; v.ab = ab; v.ld = ld; v.hl = hl;
        v.st = st; v.step = step; v.clr = clr; v.busy = busy; v.done = done;
        v.cnt = cnt;
        return v;
    endfunction

    initial begin
        int steps_seen, clears_seen;

        //                 sr sd rq ab ld hl   st step clr busy done cnt
        vecs[0]  = mk(1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 0,   4, 1, 0, 1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 0,   3, 0, 0, 1, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 1);
        vecs[6]  = mk(0, 0, 1, 0, 0, 0,   4, 1, 0, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 2);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0,   3, 0, 0, 1, 0, 2);
        vecs[9]  = mk(0, 0, 1, 0, 0, 1,   5, 0, 0, 0, 1, 2);
        vecs[10] = mk(1, 0, 0, 0, 0, 0,   5, 0, 0, 0, 1, 2);
        vecs[11] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2);
        vecs[12] = mk(1, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 1,   5, 0, 0, 0, 1, 2);
        vecs[16] = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2);

        #2;
        do_reset();

        for (int i = 0; i < NV; i++) begin
            start_run = vecs[i].sr; start_debug = vecs[i].sd;
            step_req = vecs[i].req; abort = vecs[i].ab;
            load_busy = vecs[i].ld; halt = vecs[i].hl;
            tick();
            check($sformatf("vec%0d_state", i), 64'(a_state), 64'(vecs[i].st));
            check($sformatf("vec%0d_step", i),  64'(a_step),  64'(vecs[i].step));
            check($sformatf("vec%0d_clear", i), 64'(a_clear), 64'(vecs[i].clr));
            check($sformatf("vec%0d_busy", i),  64'(a_busy),  64'(vecs[i].busy));
            check($sformatf("vec%0d_done", i),  64'(a_done),  64'(vecs[i].done));
            check($sformatf("vec%0d_count", i), 64'(a_cnt),   64'(vecs[i].cnt));
        end
        clear_inputs();

        // Continuous run with halt after 10 step cycles.
        do_reset();
        steps_seen = 0; clears_seen = 0;
        start_run = 1;
        tick();
        clears_seen += int'(a_clear);
        start_run = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            steps_seen  += int'(a_step);
            clears_seen += int'(a_clear);
        end
        halt = 1;
        tick();
        steps_seen  += int'(a_step);
        halt = 0;
        check("run10_steps",  64'(steps_seen), 64'd10);
        check("run10_clears", 64'(clears_seen), 64'd1);
        check("run10_count",  64'(a_cnt), 64'd10);
        check("run10_done",   64'(a_done), 64'd1);
        check("run10_state",  64'(a_state), 64'd5);

        // Three single steps four cycles apart, plus a dropped request.
        do_reset();
        start_debug = 1;
        tick();
        start_debug = 0;
        tick();
        steps_seen = 0;
        for (int p = 0; p < 3; p++) begin
            step_req = 1;
            tick();
            steps_seen += int'(a_step);
            step_req = (p == 1);
            tick();
            steps_seen += int'(a_step);
            step_req = 0;
            for (int k = 0; k < 2; k++) begin
                tick();
                steps_seen += int'(a_step);
            end
        end
        check("dbg3_steps", 64'(steps_seen), 64'd3);
        check("dbg3_count", 64'(a_cnt), 64'd3);
        check("dbg3_state", 64'(a_state), 64'd3);

        // Saturation of the 4-bit counter, then abort keeps the value.
        abort = 1;
        tick();
        abort = 0;
        start_run = 1;
        tick();
        start_run = 0;
        for (int i = 0; i < 20; i++) tick();
        halt = 1;
        tick();
        halt = 0;
        check("sat_count4",  64'(b_cnt), 64'd15);
        check("sat_count32", 64'(a_cnt), 64'd20);
        abort = 1;
        tick();
        abort = 0;
        check("sat_abort_state", 64'(b_state), 64'd0);
        check("sat_abort_count", 64'(b_cnt), 64'd15);

        // Asynchronous reset in the middle of a run.
        start_run = 1;
        tick();
        start_run = 0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_step",  64'(a_step),  64'd0);
        check("arst_clear", 64'(a_clear), 64'd0);
        check("arst_busy",  64'(a_busy),  64'd0);
        check("arst_done",  64'(a_done),  64'd0);
        check("arst_state", 64'(a_state), 64'd0);
        check("arst_count", 64'(a_cnt),   64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("arst_after_state", 64'(a_state), 64'd0);
        check("arst_after_step",  64'(a_step),  64'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                start_run   = ($urandom_range(0, 7) == 0);
                start_debug = ($urandom_range(0, 5) == 0);
                step_req    = ($urandom_range(0, 2) == 0);
                abort       = ($urandom_range(0, 59) == 0);
                load_busy   = ($urandom_range(0, 4) == 0);
                halt        = ($urandom_range(0, 24) == 0);
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
